// File: rtl/flit_mux_arbiter.sv
// flit_mux_arbiter: round-robin, packet-locked 2:1 flit merge with a
// 1-entry registered output stage and a packet length watchdog.
module flit_mux_arbiter #(
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_tail,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_tail,
  output logic       b_ready,
  output logic       sel,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_tail,
  input  logic       o_ready,
  output logic       pkt_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t        state;
  logic          last_b;
  logic [CW-1:0] cnt;

  logic          out_free;
  logic          xfer_a;
  logic          xfer_b;
  logic          xfer;
  logic [DW-1:0] x_data;
  logic          x_tail;
  logic          wd_hit;

  // sel is a pure decode of the registered grant state
  assign sel = (state == GNT_B);

  // Handshake and muxed flit selection for the current cycle
  always_comb begin
    out_free = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    xfer_a   = 1'b0;
    xfer_b   = 1'b0;
    xfer     = 1'b0;
    x_data   = '0;
    x_tail   = 1'b0;
    wd_hit   = 1'b0;

    out_free = !o_valid || o_ready;
    a_ready  = (state == GNT_A) && out_free;
    b_ready  = (state == GNT_B) && out_free;
    xfer_a   = a_ready && a_valid;
    xfer_b   = b_ready && b_valid;
    xfer     = xfer_a || xfer_b;
    x_data   = sel ? b_data : a_data;
    x_tail   = sel ? b_tail : a_tail;
    // Runaway packet: this non-tail flit is the last one allowed
    wd_hit   = xfer && !x_tail && (cnt == CW'(MAX_PKT_LEN - 1));
  end

  // Grant FSM, output register and watchdog counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tail  <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      pkt_err <= wd_hit;

      if (xfer) begin
        o_valid <= 1'b1;
        o_data  <= x_data;
        o_tail  <= x_tail || wd_hit;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (a_valid && (!b_valid || last_b)) begin
            state <= GNT_A;
          end else if (b_valid) begin
            state <= GNT_B;
          end
        end
        GNT_A, GNT_B: begin
          if (xfer) begin
            if (x_tail || wd_hit) begin
              state  <= IDLE;
              last_b <= (state == GNT_B);
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_mux_arbiter.sv
// tb_flit_mux_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a packet-level reference model.
module tb_flit_mux_arbiter;

  localparam int MAXL = 4;

  logic       clk;
  logic       reset;
  logic       a_valid, a_tail, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_tail, b_ready;
  logic [7:0] b_data;
  logic       sel, o_valid, o_tail, o_ready, pkt_err;
  logic [7:0] o_data;

  flit_mux_arbiter #(.MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_tail(a_tail), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_tail(b_tail), .b_ready(b_ready),
    .sel(sel), .o_valid(o_valid), .o_data(o_data), .o_tail(o_tail),
    .o_ready(o_ready), .pkt_err(pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       t;
  } flit_t;

  typedef struct {
    logic [7:0] d;
    logic       t;
    int         cyc;
  } ent_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_seen = 0;
  int ar_hi = 0;

  // Source streams, output log and reference model state
  flit_t qa[$];
  flit_t qb[$];
  flit_t outq[$];
  ent_t  logq[$];
  int    owner;      // 0 = nobody, 1 = A, 2 = B
  bit    last_b;
  int    pkt_len;
  bit    err_exp;
  bit    acc_a, acc_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; last_b = 1'b1; pkt_len = 0; err_exp = 1'b0;
    outq.delete();
  endtask

  // Compare DUT outputs with the model for the current cycle
  task automatic check_outputs();
    bit free;
    free = (outq.size() == 0) || o_ready;
    chk("a_ready", a_ready, (owner == 1) && free);
    chk("b_ready", b_ready, (owner == 2) && free);
    chk("sel", sel, owner == 2);
    chk("o_valid", o_valid, outq.size() != 0);
    if (outq.size() != 0) begin
      chk("o_data", o_data, outq[0].d);
      chk("o_tail", o_tail, outq[0].t);
    end
    chk("pkt_err", pkt_err, err_exp);
    acc_a = a_valid && (owner == 1) && free;
    acc_b = b_valid && (owner == 2) && free;
    if (o_valid && o_ready) logq.push_back('{o_data, o_tail, cyc});
    if (pkt_err) err_seen++;
    if (a_ready) ar_hi++;
  endtask

  // Advance the model across one clock edge using packet-level rules
  task automatic model_update();
    flit_t f;
    if (outq.size() != 0 && o_ready) void'(outq.pop_front());
    err_exp = 1'b0;
    if (owner == 0) begin
      if (a_valid && (!b_valid || last_b)) owner = 1;
      else if (b_valid) owner = 2;
    end else if (acc_a || acc_b) begin
      f.d = acc_a ? a_data : b_data;
      f.t = acc_a ? a_tail : b_tail;
      pkt_len++;
      if (!f.t && pkt_len == MAXL) begin
        err_exp = 1'b1;
        f.t = 1'b1;
      end
      outq.push_back(f);
      if (f.t) begin
        last_b  = (owner == 2);
        owner   = 0;
        pkt_len = 0;
      end
    end
    if (acc_a) void'(qa.pop_front());
    if (acc_b) void'(qb.pop_front());
  endtask

  task automatic drive(input bit ordy, input bit ga, input bit gb);
    o_ready = ordy;
    a_valid = (qa.size() != 0) && !ga;
    a_data  = (qa.size() != 0) ? qa[0].d : 8'h00;
    a_tail  = (qa.size() != 0) ? qa[0].t : 1'b0;
    b_valid = (qb.size() != 0) && !gb;
    b_data  = (qb.size() != 0) ? qb[0].d : 8'h00;
    b_tail  = (qb.size() != 0) ? qb[0].t : 1'b0;
  endtask

  // One cycle: drive at negedge, check, then cross the rising edge
  task automatic step(input bit ordy, input bit ga, input bit gb);
    drive(ordy, ga, gb);
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    qa.delete(); qb.delete(); logq.delete();
    err_seen = 0; ar_hi = 0; cyc = 0;
  endtask

  task automatic push(input bit to_b, input logic [7:0] d, input logic t);
    flit_t f;
    f.d = d; f.t = t;
    if (to_b) qb.push_back(f);
    else qa.push_back(f);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 0; a_data = 0; a_tail = 0;
    b_valid = 0; b_data = 0; b_tail = 0;
    o_ready = 0;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);

    // 1: three-flit A packet, latency and tail placement
    do_reset();
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    run(8);
    chk("t1_count", logq.size(), 3);
    if (logq.size() == 3) begin
      chk("t1_d0", logq[0].d, 8'h11);
      chk("t1_d1", logq[1].d, 8'h22);
      chk("t1_d2", logq[2].d, 8'h33);
      chk("t1_tails", {logq[0].t, logq[1].t, logq[2].t}, 3'b001);
      chk("t1_lat", logq[0].cyc, 2);
      chk("t1_b2b", logq[2].cyc - logq[0].cyc, 2);
    end

    // 2: alternating single-flit packets with one bubble
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 8'hA0 + 8'(i), 1);
      push(1, 8'hB0 + 8'(i), 1);
    end
    run(20);
    chk("t2_count", logq.size(), 6);
    if (logq.size() >= 4) begin
      chk("t2_order", {logq[0].d, logq[1].d, logq[2].d, logq[3].d}, 32'hA0B0A1B1);
      chk("t2_gap", logq[1].cyc - logq[0].cyc, 2);
    end

    // 3: downstream stall mid-packet
    do_reset();
    push(0, 8'h31, 0); push(0, 8'h32, 0); push(0, 8'h33, 1);
    for (int i = 0; i < 12; i++) step(!(i >= 2 && i < 5), 1'b0, 1'b0);
    chk("t3_count", logq.size(), 3);
    if (logq.size() == 3)
      chk("t3_data", {8'h00, logq[0].d, logq[1].d, logq[2].d}, 32'h00313233);

    // 4: watchdog closes a runaway B packet
    do_reset();
    for (int i = 0; i < 6; i++) push(1, 8'h41 + 8'(i), 0);
    run(16);
    chk("t4_count", logq.size(), 6);
    if (logq.size() == 6)
      chk("t4_tails", {logq[0].t, logq[1].t, logq[2].t, logq[3].t, logq[4].t, logq[5].t}, 6'b000100);
    chk("t4_err_pulses", err_seen, 1);

    // 5: granted B stalls; A must wait for B's tail
    do_reset();
    push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) push(0, 8'h61, 1);
      if (i == 9) chk("t5_a_blocked", ar_hi, 0);
      step(1'b1, 1'b0, (i >= 2 && i < 7));
    end
    chk("t5_count", logq.size(), 4);
    if (logq.size() == 4)
      chk("t5_order", {logq[0].d, logq[1].d, logq[2].d, logq[3].d}, 32'h51525361);

    // 6: async reset with a flit held in the output stage
    do_reset();
    push(0, 8'h71, 0); push(0, 8'h72, 0); push(0, 8'h73, 1);
    for (int i = 0; i < 10 && !o_valid; i++) step(1'b0, 1'b0, 1'b0);
    chk("t6_o_valid_seen", o_valid, 1);
    drive(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_o_valid", o_valid, 0);
    chk("t6_rst_o_data", o_data, 0);
    chk("t6_rst_o_tail", o_tail, 0);
    chk("t6_rst_a_ready", a_ready, 0);
    chk("t6_rst_sel", sel, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    qa.delete(); qb.delete(); logq.delete();
    push(0, 8'h81, 1); push(1, 8'h91, 1);
    run(10);
    chk("t6_count", logq.size(), 2);
    if (logq.size() == 2)
      chk("t6_tie_a_first", {logq[0].d, logq[1].d}, 16'h8191);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (qa.size() < 2) push(0, 8'($urandom), $urandom_range(0, 3) == 0);
      if (qb.size() < 2) push(1, 8'($urandom), $urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
